oled_spi_arbiter: RTL
=====================

Name: oled_spi_arbiter

Overview:
- Shares the single SPI byte writer (`ena_write` / `oled_dc` / `data` in, `write_done` back) between three byte sources:
  - requester 0: power-up init sequencer
  - requester 1: frame-RAM refresh reader
  - requester 2: runtime command port (contrast, display on/off)
- Round-robin arbitration with per-requester lock, so a page burst (3 address commands + 128 data bytes) is never interleaved.
- Watchdog on `write_done`.
- Sits between the OLED byte sources and the SPI writer.

Parameters:
- TIMEOUT, 200_000, max cycles to wait for `write_done` after `ena_write`; 0 disables the watchdog.
- TO_W, 18, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  3  bit i: requester i has a byte pending
- req_lock  in  3  bit i: requester i keeps the grant after its current byte
- req_dc  in  3  bit i: dc for requester i's byte (0 = command, 1 = data)
- req_data  in  24  byte of requester i at [8i+7:8i]
- req_ready  out  3  one-cycle pulse: requester i's byte captured; present the next byte from the following cycle
- req_done  out  3  one-cycle pulse: requester i's byte finished on SPI
- grant  out  3  one-hot current owner; 0 when free
- busy  out  1  high while a byte is in flight (state WAIT)
- timeout_err  out  1  one-cycle pulse on watchdog expiry
- ena_write  out  1  one-cycle start pulse to the SPI writer
- oled_dc  out  1  dc to the SPI writer
- data  out  8  byte to the SPI writer
- write_done  in  1  SPI writer completion pulse

Behaviour:
- Single clock `clk`; asynchronous active-low reset `rst_n`.
- All outputs are registered.

Reset values (applied immediately, also mid-transfer):
- `ena_write`=0, `oled_dc`=1, `data`=0, `grant`=0, `req_ready`=0, `req_done`=0, `busy`=0, `timeout_err`=0.
- Round-robin pointer = 0; state = IDLE; lock-hold flag cleared.
- An in-flight byte is abandoned and no `req_done` is issued for it.

States: IDLE, WAIT.

IDLE, grant free:
- Scan `req_valid` starting at the pointer, wrapping 0→1→2→0; the first set bit i wins.
- On the clock edge:
  - `grant`=onehot(i)
  - `data`=req_data[i], `oled_dc`=req_dc[i]
  - `ena_write`=1 for one cycle, `req_ready[i]`=1 for one cycle
  - `busy`=1, state→WAIT
- No valid requester: stay in IDLE; outputs hold, except the pulses, which stay 0.

IDLE, grant held (lock-hold flag set):
- Only the owner's `req_valid` is considered; other requesters are blocked.
- Owner valid: issue its byte exactly as above.
- Owner not valid and its `req_lock`=0: clear `grant` and the flag; the pointer moves to owner+1 (mod 3). Arbitration resumes the following cycle.
- Owner not valid and its `req_lock`=1: wait indefinitely.

WAIT:
- `ena_write` returns to 0 the cycle after issue.
- `write_done` is sampled every WAIT cycle, including the first.
- On `write_done`:
  - `req_done[owner]`=1 for one cycle; `busy`=0; state→IDLE.
  - If `req_lock[owner]`=1 in that cycle: set the lock-hold flag and keep `grant`.
  - Otherwise: clear `grant` and set pointer = owner+1 (mod 3).
- `write_done` outside WAIT is ignored.

Watchdog:
- Counter clears on issue and increments each WAIT cycle.
- When the counter equals TIMEOUT and `write_done` is absent:
  - `timeout_err`=1 for one cycle; no `req_done`.
  - Grant is released regardless of lock; pointer = owner+1 (mod 3).
  - `busy`=0; state→IDLE.
- `write_done` and expiry in the same cycle: completion wins and no error is raised.

Timing:
- Throughput: `write_done` at cycle W → IDLE at W+1 → next `ena_write` at W+2 (one idle cycle per byte minimum).
- Latency: valid seen in IDLE at cycle T → `ena_write` and `req_ready` high during cycle T+1.
- Requesters must hold `req_data`/`req_dc` stable while `req_valid` is high and `req_ready` has not yet pulsed.

Test Plan:
- Single request: req0 valid, dc=0, data=8'hAE, `write_done` 20 cycles after `ena_write` → `ena_write`+`req_ready[0]` 1 cycle after valid; `data`=AE, `oled_dc`=0; `req_done[0]` 1 cycle after `write_done`; `grant` returns to 0.
- Round-robin: all three valid continuously, no lock → byte order 0,1,2,0,1,2; `ena_write` spacing = done-delay + 2 cycles.
- Lock burst: req1 lock=1 for 131 bytes (3 cmds dc=0, then 128 data dc=1) while req2 valid throughout → all 131 bytes issued from req1 uninterrupted; req2's byte is issued right after req1 drops lock.
- Lock stall: req1 holds lock with valid low for 50 cycles while req0 valid → no `ena_write`; `grant` stays 010 until the lock drops, then req2 scanned first, then req0.
- Timeout: TIMEOUT=16, `write_done` never arrives → `timeout_err` pulse 16 WAIT cycles after issue; no `req_done`; `grant`=0; next arbitration starts at owner+1.
- Reset mid-WAIT: assert `rst_n`=0 while `busy` → outputs at reset values immediately; a later `write_done` produces no `req_done`.

Source files
------------

// File: rtl/oled_spi_arbiter.sv
// rtl/oled_spi_arbiter.sv - round-robin arbiter with burst lock and write_done watchdog in front of the OLED SPI byte writer
//
// Purpose:
//   Three byte sources (0: power-up init, 1: frame-RAM refresh, 2: runtime
//   commands) share one SPI byte writer. A requester that raises req_lock
//   keeps the grant across bytes, so a page burst is never interleaved.
//   A watchdog abandons a byte whose write_done never comes back.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[2:0]    requester i has a byte pending
//   req_lock[2:0]     requester i keeps the grant after its current byte
//   req_dc[2:0]       dc of requester i's byte (0 command, 1 data)
//   req_data[23:0]    byte of requester i at [8i+7:8i]
//   req_ready[2:0]    one-cycle pulse: requester i's byte captured
//   req_done[2:0]     one-cycle pulse: requester i's byte finished on SPI
//   grant[2:0]        one-hot current owner, 0 when free
//   busy              a byte is in flight
//   timeout_err       one-cycle pulse on watchdog expiry
//   ena_write         one-cycle start pulse to the SPI writer
//   oled_dc, data     dc and byte presented to the SPI writer
//   write_done        SPI writer completion pulse

module oled_spi_arbiter #(
    parameter int TIMEOUT = 200_000,
    parameter int TO_W    = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_valid,
    input  logic [2:0]  req_lock,
    input  logic [2:0]  req_dc,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    output logic [2:0]  req_done,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        timeout_err,
    output logic        ena_write,
    output logic        oled_dc,
    output logic [7:0]  data,
    input  logic        write_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // The counter holds the number of WAIT cycles already spent; expiry is
    // decided in the WAIT cycle that would bring it to TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam bit              TO_EN   = (TIMEOUT > 0);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        owner_q, owner_d;
    logic              hold_q, hold_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        req_ready_q, req_ready_d;
    logic [2:0]        req_done_q, req_done_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic              ena_write_q, ena_write_d;
    logic              oled_dc_q, oled_dc_d;
    logic [7:0]        data_q, data_d;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    next_idx = 2'd1;
            2'd1:    next_idx = 2'd2;
            default: next_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [23:0] bytes, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = bytes[7:0];
            2'd1:    byte_of = bytes[15:8];
            default: byte_of = bytes[23:16];
        endcase
    endfunction

    // Round-robin scan: pointer first, then the two that follow it.
    logic [1:0] cand0, cand1, cand2;
    logic       pick_found;
    logic [1:0] pick_idx;

    always_comb begin
        cand0      = ptr_q;
        cand1      = next_idx(cand0);
        cand2      = next_idx(cand1);
        pick_found = 1'b1;
        pick_idx   = cand0;
        if (req_valid[cand0]) begin
            pick_idx = cand0;
        end else if (req_valid[cand1]) begin
            pick_idx = cand1;
        end else if (req_valid[cand2]) begin
            pick_idx = cand2;
        end else begin
            pick_found = 1'b0;
        end
    end

    logic       issue_en;
    logic [1:0] issue_idx;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        hold_d        = hold_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        busy_d        = busy_q;
        oled_dc_d     = oled_dc_q;
        data_d        = data_q;
        ena_write_d   = 1'b0;
        req_ready_d   = 3'b000;
        req_done_d    = 3'b000;
        timeout_err_d = 1'b0;
        issue_en      = 1'b0;
        issue_idx     = owner_q;

        case (state_q)
            S_IDLE: begin
                if (hold_q) begin
                    // Locked owner: everybody else is blocked until it lets go.
                    if (req_valid[owner_q]) begin
                        issue_en  = 1'b1;
                        issue_idx = owner_q;
                    end else if (!req_lock[owner_q]) begin
                        grant_d = 3'b000;
                        hold_d  = 1'b0;
                        ptr_d   = next_idx(owner_q);
                    end
                end else if (pick_found) begin
                    issue_en  = 1'b1;
                    issue_idx = pick_idx;
                end
            end

            S_WAIT: begin
                // Completion is checked before expiry so a write_done landing on
                // the last allowed cycle still counts as success.
                if (write_done) begin
                    req_done_d = onehot(owner_q);
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                    if (req_lock[owner_q]) begin
                        hold_d = 1'b1;
                    end else begin
                        hold_d  = 1'b0;
                        grant_d = 3'b000;
                        ptr_d   = next_idx(owner_q);
                    end
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                    hold_d        = 1'b0;
                    grant_d       = 3'b000;
                    ptr_d         = next_idx(owner_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_en) begin
            owner_d     = issue_idx;
            grant_d     = onehot(issue_idx);
            data_d      = byte_of(req_data, issue_idx);
            oled_dc_d   = req_dc[issue_idx];
            ena_write_d = 1'b1;
            req_ready_d = onehot(issue_idx);
            busy_d      = 1'b1;
            cnt_d       = '0;
            state_d     = S_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 2'd0;
            owner_q       <= 2'd0;
            hold_q        <= 1'b0;
            cnt_q         <= '0;
            grant_q       <= 3'b000;
            req_ready_q   <= 3'b000;
            req_done_q    <= 3'b000;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            ena_write_q   <= 1'b0;
            oled_dc_q     <= 1'b1;
            data_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            hold_q        <= hold_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            req_ready_q   <= req_ready_d;
            req_done_q    <= req_done_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            ena_write_q   <= ena_write_d;
            oled_dc_q     <= oled_dc_d;
            data_q        <= data_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign req_done    = req_done_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign ena_write   = ena_write_q;
    assign oled_dc     = oled_dc_q;
    assign data        = data_q;

endmodule
